// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type, widths and helpers for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StDlv,
    StDrain,
    StHalt
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned LINE_W  = 64;

  localparam logic [INSTR_W-1:0] INSTR_HALT = 32'h0;

  // Bus addresses are always whole 8-byte lines.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return addr & ~64'h7;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 64-bit lines and offers their two instructions to decode one at a time.
// Define FETCH_TRACE_EN to print handshakes, redirects and halt entry.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  entry_pc,
  output logic               bus_req,
  output logic [ADDR_W-1:0]  bus_addr,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  target_pc;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [INSTR_W-1:0] sel_word;
  logic               handshake;

  assign target_pc = redirect_pc & ~ADDR_W'(3);
  assign sel_word  = pc_q[2] ? line_q[LINE_W-1:INSTR_W] : line_q[INSTR_W-1:0];
  assign handshake = instr_valid & instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    line_d  = line_q;
    unique case (state_q)
      StReq: begin
        if (redirect_valid) begin
          pc_d = target_pc;
          // A granted request still owes us a beat, so it must be drained.
          state_d = bus_gnt ? StDrain : StReq;
        end else if (bus_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d    = target_pc;
          state_d = bus_rvalid ? StReq : StDrain;
        end else if (bus_rvalid) begin
          line_d  = bus_rdata[LINE_W-1:0];
          state_d = StDlv;
        end
      end
      StDlv: begin
        if (redirect_valid) begin
          pc_d    = target_pc;
          state_d = StReq;
        end else if (sel_word == INSTR_HALT) begin
          state_d = StHalt;
        end else if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = pc_q[2] ? StReq : StDlv;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          pc_d = target_pc;
        end
        if (bus_rvalid) begin
          state_d = StReq;
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          pc_d    = target_pc;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReq;
      pc_q    <= entry_pc & ~ADDR_W'(3);
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      line_q  <= line_d;
    end
  end

  // Reset is synchronous but still masks the outputs in the reset cycle itself.
  assign bus_req     = ~reset & (state_q == StReq);
  assign bus_addr    = ADDR_W'(line_align(64'(pc_q)));
  assign instr_valid = ~reset & (state_q == StDlv) & (sel_word != INSTR_HALT);
  assign instr       = instr_valid ? sel_word : '0;
  assign instr_pc    = instr_valid ? pc_q : '0;
  assign halted      = ~reset & (state_q == StHalt);

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (handshake) begin
        $display("fetch pc=%h instr=%h", instr_pc, instr);
      end
      if (redirect_valid) begin
        $display("redirect %h", redirect_pc);
      end
      if (state_d == StHalt && state_q != StHalt) begin
        $display("halt pc=%h", pc_q);
      end
    end
  end
`else
  // Default build: handshake is only observed by the trace.
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand-written redirect/reset sequences and a
// randomized bus/decoder environment checked against an instruction-stream model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry_pc;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W(64),
    .DATA_W(64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_pc      (entry_pc),
    .bus_req       (bus_req),
    .bus_addr      (bus_addr),
    .bus_gnt       (bus_gnt),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  typedef struct packed {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [63:0] rdata;
    logic        rdir;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_halted;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic gnt, input logic rv,
                             input logic [63:0] rdata, input logic rdir, input logic [63:0] rpc,
                             input logic rdy, input logic e_req, input logic [63:0] e_addr,
                             input logic e_valid, input logic [31:0] e_instr,
                             input logic [63:0] e_pc, input logic e_halted);
    vec_t r;
    r = '{rst, gnt, rv, rdata, rdir, rpc, rdy, e_req, e_addr, e_valid, e_instr, e_pc, e_halted};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic gnt, input logic rv, input logic [63:0] rdata,
                       input logic rdir, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    reset          = rst;
    bus_gnt        = gnt;
    bus_rvalid     = rv;
    bus_rdata      = rdata;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
  endtask

  task automatic exp_io(input string tag, input logic req, input logic [63:0] addr,
                        input logic valid, input logic [31:0] ins, input logic [63:0] pc);
    check({tag, " bus_req"}, 64'(bus_req), 64'(req));
    if (req) check({tag, " bus_addr"}, bus_addr, addr);
    check({tag, " instr_valid"}, 64'(instr_valid), 64'(valid));
    if (valid) begin
      check({tag, " instr"}, 64'(instr), 64'(ins));
      check({tag, " instr_pc"}, instr_pc, pc);
    end
  endtask

  // Reference memory: address-dependent words, occasionally zero to trigger halts.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    h = (a[31:0] ^ {a[63:34], 2'b00}) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    if (h[31:26] == 6'd0) return 32'h0;
    return h | 32'h3;
  endfunction

  function automatic logic [63:0] mem_line(input logic [63:0] a);
    logic [63:0] base;
    base = a & ~64'h7;
    return {mem_word(base + 64'd4), mem_word(base)};
  endfunction

  function automatic logic [63:0] pick_pc();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    return 64'($urandom_range(0, 65535));
  endfunction

  localparam logic [63:0] Z = 64'h0;

  vec_t vecs[$];

  // Random-phase state
  logic [63:0] exp_pc;
  logic        outstanding;
  logic [63:0] out_addr;
  int          rdelay;
  int          halt_cnt;
  int          idle;
  logic        prev_req, prev_gnt, prev_rdir;
  logic [63:0] prev_addr;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; entry_pc = 64'h1000; bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; instr_ready = 0;

    // Sequential fetch, backpressure, halt, redirect out of halt and refetch.
    vecs.push_back(v(1, 0, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 1, 0, Z, 0, Z, 0, 1, 64'h1000, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 1, 64'h00500093_00100093, 0, Z, 0, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 1, 32'h00100093, 64'h1000, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 0, Z, 1, 32'h00500093, 64'h1004, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 1, 32'h00500093, 64'h1004, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 1, 64'h1008, 0, 0, Z, 0));
    vecs.push_back(v(0, 1, 0, Z, 0, Z, 0, 1, 64'h1008, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 1, 64'h00000000_00700093, 0, Z, 0, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 1, 32'h00700093, 64'h1008, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z, 1));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z, 1));
    vecs.push_back(v(0, 0, 0, Z, 1, 64'h1000, 0, 0, Z, 0, 0, Z, 1));
    vecs.push_back(v(0, 1, 0, Z, 0, Z, 0, 1, 64'h1000, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 1, 64'h00000000_00100093, 0, Z, 0, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 1, 32'h00100093, 64'h1000, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 1, 0, Z, 0, 0, Z, 0));
    vecs.push_back(v(0, 0, 0, Z, 0, Z, 0, 0, Z, 0, 0, Z, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdir, vecs[i].rpc,
            vecs[i].rdy);
      exp_io($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
             vecs[i].e_instr, vecs[i].e_pc);
      check($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].e_halted));
      if (vecs[i].rst) begin
        check($sformatf("vec%0d rst instr", i), 64'(instr), Z);
        check($sformatf("vec%0d rst instr_pc", i), instr_pc, Z);
      end
    end

    // Redirect in WAIT; stale beat arrives three cycles later and must be dropped.
    entry_pc = 64'h1000;
    drive(1, 0, 0, Z, 0, Z, 0);
    drive(0, 1, 0, Z, 0, Z, 1);             exp_io("rw grant", 1, 64'h1000, 0, 0, Z);
    drive(0, 0, 0, Z, 1, 64'h2004, 1);      exp_io("rw redirect", 0, Z, 0, 0, Z);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("rw drain1", 0, Z, 0, 0, Z);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("rw drain2", 0, Z, 0, 0, Z);
    drive(0, 0, 1, 64'hDEADBEEF_CAFEF00D, 0, Z, 1); exp_io("rw stale", 0, Z, 0, 0, Z);
    drive(0, 1, 0, Z, 0, Z, 1);             exp_io("rw refetch", 1, 64'h2000, 0, 0, Z);
    drive(0, 0, 1, 64'h11111113_22222213, 0, Z, 1); exp_io("rw beat", 0, Z, 0, 0, Z);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("rw high only", 0, Z, 1, 32'h11111113, 64'h2004);
    // Redirect coincident with a handshake.
    drive(0, 1, 0, Z, 0, Z, 1);             exp_io("rc next line", 1, 64'h2008, 0, 0, Z);
    drive(0, 0, 1, 64'h33333313_44444413, 0, Z, 1); exp_io("rc beat", 0, Z, 0, 0, Z);
    drive(0, 0, 0, Z, 1, 64'h3000, 1);      exp_io("rc handshake", 0, Z, 1, 32'h44444413, 64'h2008);
    drive(0, 1, 0, Z, 0, Z, 1);             exp_io("rc target", 1, 64'h3000, 0, 0, Z);
    drive(0, 0, 1, 64'h55555513_66666613, 0, Z, 1); exp_io("rc beat2", 0, Z, 0, 0, Z);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("rc low", 0, Z, 1, 32'h66666613, 64'h3000);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("rc high", 0, Z, 1, 32'h55555513, 64'h3004);
    // Reset mid-WAIT, then redirect in REQ without a grant.
    drive(0, 1, 0, Z, 0, Z, 1);             exp_io("rst grant", 1, 64'h3008, 0, 0, Z);
    entry_pc = 64'h4000;
    drive(1, 0, 0, Z, 0, Z, 1);             exp_io("rst cycle", 0, Z, 0, 0, Z);
    check("rst halted", 64'(halted), Z);
    check("rst instr", 64'(instr), Z);
    check("rst instr_pc", instr_pc, Z);
    drive(0, 0, 0, Z, 1, 64'h5008, 1);      exp_io("rst after", 1, 64'h4000, 0, 0, Z);
    drive(0, 0, 0, Z, 0, Z, 1);             exp_io("req redirect", 1, 64'h5008, 0, 0, Z);

    // Randomized phase against the instruction-stream model.
    entry_pc = pick_pc();
    drive(1, 0, 0, Z, 0, Z, 0);
    exp_pc = entry_pc & ~64'h3;
    outstanding = 0; out_addr = '0; rdelay = 0; halt_cnt = 0; idle = 0;
    prev_req = 0; prev_gnt = 0; prev_rdir = 0; prev_addr = '0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = 0; bus_gnt = 0; bus_rvalid = 0; redirect_valid = 0;
      bus_rdata = {$urandom, $urandom};
      #1;
      if (outstanding && rdelay == 0) begin
        bus_rvalid = 1;
        bus_rdata  = mem_line(out_addr);
      end
      if (bus_req && !outstanding && $urandom_range(0, 2) != 0) bus_gnt = 1;
      instr_ready = ($urandom_range(0, 3) != 0);
      if (halt_cnt >= 3 || $urandom_range(0, 24) == 0) begin
        redirect_valid = 1;
        redirect_pc    = pick_pc();
      end
      #1;

      if (bus_req) begin
        check("rnd one_outstanding", 64'(outstanding), Z);
        check("rnd addr_aligned", 64'(bus_addr[2:0]), Z);
      end
      if (prev_req && !prev_gnt && !prev_rdir) begin
        check("rnd req_held", 64'(bus_req), 64'd1);
        check("rnd addr_stable", bus_addr, prev_addr);
      end
      check("rnd halted", 64'(halted), (halted && mem_word(exp_pc) == 32'h0) ? 64'd1 : Z);
      if (instr_valid && instr_ready) begin
        check("rnd instr_pc", instr_pc, exp_pc);
        check("rnd instr", 64'(instr), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~64'h3;
        idle = 0;
      end
      halt_cnt = halted ? halt_cnt + 1 : 0;
      if (halted) idle = 0;
      if (idle > 80) begin
        check("rnd progress_timeout", 64'(idle), 64'd80);
        idle = 0;
      end

      if (bus_rvalid) outstanding = 0;
      else if (outstanding) rdelay--;
      if (bus_gnt) begin
        outstanding = 1;
        out_addr    = bus_addr;
        rdelay      = $urandom_range(0, 3);
      end
      prev_req  = bus_req;
      prev_gnt  = bus_gnt;
      prev_rdir = redirect_valid;
      prev_addr = bus_addr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction decoder: fetches 64-bit words from the system bus, splits each into two 32-bit RV64 instructions, and presents them one at a time to the decode stage over a valid/ready handshake.
- Replaces duplicate-instruction suppression inside the decoder: each fetched instruction is offered exactly once, and the decoder only samples on a completed handshake.
- Handles PC sequencing, branch/jump redirects including discard of in-flight bus responses, and halt on an all-zero instruction word.

Parameters:
- ADDR_W, 64, width of PC and bus address.
- DATA_W, 64, bus read data width; fixed at 64, two instructions per beat.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- entry_pc  in  ADDR_W  start PC, sampled while reset=1.
- bus_req  out  1  read request, held until granted.
- bus_addr  out  ADDR_W  8-byte-aligned read address, stable while bus_req=1.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid; exactly one beat per granted request.
- bus_rdata  in  DATA_W  read data, little-endian; [31:0] at lower address.
- redirect_valid  in  1  one-cycle PC redirect from branch/jump resolution.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0.
- instr_valid  out  1  instruction available to decoder.
- instr_ready  in  1  decoder accepts instruction.
- instr  out  32  instruction word.
- instr_pc  out  ADDR_W  PC of instr.
- halted  out  1  zero instruction reached.

Behaviour:
- Reset:
  - state=REQ; pc={entry_pc[ADDR_W-1:2],2'b0}.
  - bus_req, instr_valid and halted are 0 in the reset cycle; instr=0 and instr_pc=0.
  - Reset in any state, including mid-transaction, abandons all state; no drain is performed.
- States: REQ, WAIT, DLV, DRAIN, HALT.
- REQ:
  - bus_req=1, bus_addr={pc[ADDR_W-1:3],3'b0}.
  - On bus_gnt, go to WAIT.
- WAIT:
  - On bus_rvalid, latch bus_rdata into the line buffer.
  - Select half = pc[2].
  - Go to DLV next cycle.
  - Minimum gnt-to-instr_valid latency is 2 cycles: rvalid in the cycle after gnt, instr_valid one cycle after rvalid.
- DLV:
  - instr_valid=1; instr = half ? line[63:32] : line[31:0]; instr_pc=pc.
  - Outputs are stable until instr_ready.
  - On handshake: pc+=4. If the delivered half was low, stay in DLV with the high half. If it was high, go to REQ; pc then lands on the next 8-byte line, with wrap-around modulo 2^ADDR_W.
- Zero instruction:
  - If the selected word is 32'h0, instr_valid stays 0 and the FSM goes to HALT.
  - halted=1 from the next cycle.
- HALT:
  - No bus activity; halted held at 1.
  - Left only by redirect_valid (to REQ at redirect_pc, halted cleared) or by reset.
- Redirect (priority over everything except reset), with pc←redirect_pc next cycle:
  - In REQ without bus_gnt: go to REQ; bus_addr changes next cycle (legal, request not yet accepted).
  - In REQ with bus_gnt the same cycle: go to DRAIN.
  - In WAIT without bus_rvalid: go to DRAIN.
  - In WAIT with bus_rvalid the same cycle: discard the data, go to REQ.
  - In DLV: instr_valid drops next cycle; go to REQ. A handshake completing in the same cycle still counts as consumed, but the redirect PC wins.
- DRAIN:
  - bus_req=0; wait for bus_rvalid, discard it, then go to REQ.
  - A further redirect while in DRAIN only updates pc.
- Unaligned start: entry/redirect PC with pc[2]=1 delivers only the high half of the first line.
- At most one outstanding bus request at any time.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- With it defined:
  - Every completed instr handshake executes $display("fetch pc=%h instr=%h", instr_pc, instr).
  - Each redirect executes $display("redirect %h", redirect_pc).
  - Entry into HALT executes $display("halt pc=%h", pc).
- Without it: no $display statements compiled; identical cycle behaviour.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum (REQ, WAIT, DLV, DRAIN, HALT);
  - INSTR_W=32 and LINE_W=64;
  - INSTR_HALT=32'h0;
  - a line_align function that clears bits [2:0].
- No sub-module; the line buffer and half-select stay inline in the FSM.

Test Plan:
- Sequential fetch:
  - Stimulus: entry_pc=0x1000; bus returns 0x00500093_00100093 with gnt immediate and rvalid 1 cycle later; instr_ready=1.
  - Required: instr 0x00100093@0x1000, then 0x00500093@0x1004, then bus_addr=0x1008.
- Backpressure:
  - Stimulus: hold instr_ready=0 for 5 cycles in DLV.
  - Required: instr and instr_pc unchanged, instr_valid=1 throughout, no new bus_req.
- Redirect in WAIT:
  - Stimulus: redirect_pc=0x2004 one cycle after gnt; stale rvalid arrives 3 cycles later.
  - Required: stale data never appears on instr; next bus_addr=0x2000; first instr_pc=0x2004.
- Redirect coincident with handshake:
  - Stimulus: redirect_pc=0x3000 and instr_ready=1 in the same DLV cycle.
  - Required: next bus_addr=0x3000; the high half of the old line is never presented.
- Halt:
  - Stimulus: line 0x00000000_00100093 at 0x1000.
  - Required: one instr delivered; halted=1 two cycles later; bus_req=0. A later redirect to 0x1000 clears halted and refetches.
- Reset mid-WAIT:
  - Stimulus: reset=1 for one cycle while in WAIT with entry_pc=0x4000.
  - Required: bus_req=0 and instr_valid=0 during reset; next cycle bus_req=1 with bus_addr=0x4000.
